// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin token arbiter.
// Combinational-free package; no latency or backpressure of its own.
// Imported by the arbiter top.
package arb_pkg;

    localparam int N_REQ        = 16;
    localparam int IDX_W        = 4;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary index encoder built as an OR tree.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module onehot_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    // Index bit j is the OR of every input whose position has bit j set.
    always_comb begin
        idx = '0;
        for (int j = 0; j < IDX_W; j++) begin
            for (int i = 0; i < N; i++) begin
                if (((i >> j) & 1) == 1) begin
                    idx[j] = idx[j] | onehot[i];
                end
            end
        end
    end

endmodule

// File: rtl/rr_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and bounded hold time.
// Latency: grant registered one edge after REQ is sampled in idle; one idle cycle between grants.
// Backpressure: holder releases on DONE, withdrawal, or forced timeout after MAX_HOLD cycles.
module rr_token_arbiter #(
    parameter int N        = arb_pkg::N_REQ,
    parameter int IDX_W    = arb_pkg::IDX_W,
    parameter int MAX_HOLD = arb_pkg::MAX_HOLD_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     REQ,
    input  logic             DONE,
    output logic [N-1:0]     GNT,
    output logic [IDX_W-1:0] GNT_IDX,
    output logic             GNT_VLD,
    output logic             TIMEOUT
);

    import arb_pkg::*;

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    logic [N-1:0]      ptr;
    logic [HOLD_W-1:0] hold;

    logic [IDX_W-1:0]  ptr_idx;
    logic [IDX_W-1:0]  ffs;
    logic [2*N-1:0]    req_dbl;
    logic [2*N-1:0]    win_dbl;
    logic [N-1:0]      req_rot;
    logic [N-1:0]      win_rot;
    logic [N-1:0]      next_gnt;
    logic [IDX_W-1:0]  next_idx;
    logic              any_req;
    logic              rel_norm;
    logic              rel_max;

    // Rotate requests so the token position sits at bit 0, pick the lowest
    // set bit, then rotate the single winner back into place.
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) begin
                ptr_idx = ptr_idx | IDX_W'(i);
            end
        end
        req_dbl = {REQ, REQ} >> ptr_idx;
        req_rot = req_dbl[N-1:0];
        ffs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                ffs = IDX_W'(i);
            end
        end
        win_rot      = '0;
        win_rot[ffs] = any_req;
        win_dbl      = {win_rot, win_rot} << ptr_idx;
        next_gnt     = win_dbl[2*N-1:N];
    end

    assign any_req  = |REQ;
    assign rel_norm = DONE | ~|(REQ & GNT);
    assign rel_max  = (hold == HOLD_LAST);

    onehot_encoder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_enc (
        .onehot (next_gnt),
        .idx    (next_idx)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            ptr     <= N'(1);
            hold    <= '0;
            GNT     <= '0;
            GNT_IDX <= '0;
            GNT_VLD <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    TIMEOUT <= 1'b0;
                    if (any_req) begin
                        GNT     <= next_gnt;
                        GNT_IDX <= next_idx;
                        GNT_VLD <= 1'b1;
                        hold    <= '0;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (rel_norm || rel_max) begin
                        GNT     <= '0;
                        GNT_IDX <= '0;
                        GNT_VLD <= 1'b0;
                        hold    <= '0;
                        ptr     <= {GNT[N-2:0], GNT[N-1]};
                        // Timeout is flagged only when the hold limit alone forced release.
                        TIMEOUT <= rel_max & ~rel_norm;
                        state   <= ST_IDLE;
                    end else begin
                        hold    <= hold + 1'b1;
                        TIMEOUT <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
